// File: rtl/multicycle_decoder_if.sv
// Control bus between the multicycle decoder and the datapath: instruction
// fields flow in, datapath and conditional-stage controls flow out.
interface multicycle_decoder_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic [3:0]         Rd;
    logic               PCS;
    logic               RegW;
    logic               MemW;
    logic [1:0]         FlagW;
    logic               IRWrite;
    logic               NextPC;
    logic               AdrSrc;
    logic [1:0]         ResultSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUControl;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
    );

    modport slave (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
    );
endinterface

// File: rtl/multicycle_decoder.sv
// Multicycle main control unit: Moore state sequencer plus ALU and
// instruction-field decoders driving the datapath and conditional stage.
module multicycle_decoder #(
    parameter int STATE_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_decoder_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        EXECI    = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       is_cmp;
    logic       is_arith;
    logic       legal_op;
    logic [1:0] alu_control;
    logic [1:0] flag_w;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Unused encodings fall through the default arm back to FETCH.
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_next = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:  state_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: state_next = MEMWB;
            EXECR:   state_next = ALUWB;
            EXECI:   state_next = ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR:   alu_src_b = 2'b01;
            MEMREAD:  adr_src   = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR:    alu_op = 1'b1;
            EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            // Compares only set flags, so the writeback is suppressed.
            ALUWB:    reg_w = ~is_cmp;
            BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_cmp = (bus.Funct[4:1] == 4'b1010);

    always_comb begin
        alu_control = 2'b00;
        is_arith    = 1'b0;
        legal_op    = 1'b1;
        case (bus.Funct[4:1])
            4'b0100: is_arith = 1'b1;
            4'b0010: begin alu_control = 2'b01; is_arith = 1'b1; end
            4'b0000: alu_control = 2'b10;
            4'b1100: alu_control = 2'b11;
            4'b1010: begin alu_control = 2'b01; is_arith = 1'b1; end
            default: legal_op = 1'b0;
        endcase
    end

    // Flags are only written during execute, once per instruction.
    assign flag_w = (alu_op && legal_op) ? {bus.Funct[0], bus.Funct[0] & is_arith} : 2'b00;

    assign bus.PCS        = branch | ((bus.Rd == 4'd15) & reg_w);
    assign bus.RegW       = reg_w;
    assign bus.MemW       = mem_w;
    assign bus.FlagW      = flag_w;
    assign bus.IRWrite    = ir_write;
    assign bus.NextPC     = next_pc;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_op ? alu_control : 2'b00;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.State      = state;
endmodule

// File: tb/tb_multicycle_decoder.sv
// Randomized bench for multicycle_decoder: each instruction is expanded into
// its expected per-cycle trace by a reference model and compared cycle by cycle.
module tb_multicycle_decoder;
    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    multicycle_decoder_if #(.STATE_W(4)) bus ();

    multicycle_decoder #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [18:0] ctl;
    } rec_t;

    rec_t expQ[$];

    logic [18:0] obsCtl;
    assign obsCtl = {bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.IRWrite, bus.NextPC,
                     bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                     bus.ALUControl, bus.ImmSrc, bus.RegSrc};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected controls for one step of an instruction, from the opcode tables.
    function automatic logic [18:0] refCtl(input logic [3:0] st, input logic [1:0] op,
                                           input logic [5:0] funct, input logic [3:0] rd);
        logic       pcs, regw, memw, irw, npc, adr, asa;
        logic [1:0] flagw, res, asb, aluc;
        logic       flagsOk, setsCV;
        pcs = 0; regw = 0; memw = 0; irw = 0; npc = 0; adr = 0; asa = 0;
        flagw = 0; res = 0; asb = 0; aluc = 0;
        if (st == 4'd0) begin irw = 1; npc = 1; asa = 1; asb = 2'b10; res = 2'b10; end
        if (st == 4'd1) begin asa = 1; asb = 2'b10; res = 2'b10; end
        if (st == 4'd2) asb = 2'b01;
        if (st == 4'd3) adr = 1;
        if (st == 4'd4) begin res = 2'b01; regw = 1; end
        if (st == 4'd5) begin adr = 1; memw = 1; end
        if (st == 4'd7) asb = 2'b01;
        if (st == 4'd8) regw = (funct[4:1] != 4'b1010);
        if (st == 4'd9) begin asb = 2'b01; res = 2'b10; pcs = 1; end
        if (st == 4'd6 || st == 4'd7) begin
            flagsOk = 1; setsCV = 0;
            if      (funct[4:1] == 4'b0100) begin aluc = 2'd0; setsCV = 1; end
            else if (funct[4:1] == 4'b0010) begin aluc = 2'd1; setsCV = 1; end
            else if (funct[4:1] == 4'b0000) aluc = 2'd2;
            else if (funct[4:1] == 4'b1100) aluc = 2'd3;
            else if (funct[4:1] == 4'b1010) begin aluc = 2'd1; setsCV = 1; end
            else flagsOk = 0;
            if (flagsOk) flagw = {funct[0], funct[0] && setsCV};
        end
        if (regw && rd == 4'd15) pcs = 1;
        return {pcs, regw, memw, flagw, irw, npc, adr, res, asa, asb, aluc, op,
                (op == 2'b01), (op == 2'b10)};
    endfunction

    task automatic buildTrace(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        int seq[$];
        expQ.delete();
        case (op)
            2'b00:   seq = '{0, 1, (funct[5] ? 7 : 6), 8};
            2'b01:   seq = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10:   seq = '{0, 1, 9};
            default: seq = '{0, 1};
        endcase
        foreach (seq[i])
            expQ.push_back('{st: 4'(seq[i]), ctl: refCtl(4'(seq[i]), op, funct, rd)});
    endtask

    // Reset for two cycles; the unit must sit in FETCH with no write strobes.
    task automatic doReset(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("reset state c%0d", c), 32'(bus.State), 32'd0);
            checkOutput($sformatf("reset ctl c%0d", c), 32'(obsCtl), 32'(refCtl(4'd0, op, funct, rd)));
        end
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; a non-negative cut resets after that step.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                                 input logic [3:0] rd, input int cut, input string name);
        buildTrace(op, funct, rd);
        bus.Op = op; bus.Funct = funct; bus.Rd = rd;
        #1;
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s state s%0d", name, i), 32'(bus.State), 32'(expQ[i].st));
            checkOutput($sformatf("%s ctl s%0d", name, i), 32'(obsCtl), 32'(expQ[i].ctl));
            if (i == cut) begin
                doReset(op, funct, rd);
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] codes [5];
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        int         cut;
        codes = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        checkCount = 0;
        errorCount = 0;
        bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        doReset(2'b00, 6'b0, 4'd0);

        applyStimulus(2'b00, 6'b001001, 4'd3,  -1, "ADDS");
        applyStimulus(2'b01, 6'b011001, 4'd15, -1, "LDR");
        applyStimulus(2'b01, 6'b011000, 4'd2,  -1, "STR");
        applyStimulus(2'b10, 6'b100000, 4'd0,  -1, "B");
        applyStimulus(2'b00, 6'b110101, 4'd7,  -1, "CMPI");
        applyStimulus(2'b11, 6'b010101, 4'd15, -1, "NOP");
        applyStimulus(2'b00, 6'b001000, 4'd15, -1, "ADDPC");
        applyStimulus(2'b01, 6'b011000, 4'd4,   3, "STRrst");
        applyStimulus(2'b00, 6'b111001, 4'd1,   2, "ORRrst");

        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                funct = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 4)], 1'($urandom_range(0, 1))};
            else
                funct = 6'($urandom_range(0, 63));
            rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            cut = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            applyStimulus(op, funct, rd, cut, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/multicycle_decoder.md
Name: multicycle_decoder

Overview:
Main control unit for the multicycle variant of the processor. It sits directly upstream of the conditional-execution/flag stage and drives that stage's PCS, RegW, MemW and FlagW inputs. It also drives the datapath mux and enable controls.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback states.
- An ALU decoder and an instruction decoder derive the per-instruction controls from the instruction fields.

Parameters:
- STATE_W, 4, width of the state register and the state output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Op  input  2  instruction bits [27:26]; stable from DECODE until the instruction completes.
- Funct  input  6  instruction bits [25:20].
- Rd  input  4  destination register field, instruction bits [15:12].
- PCS  output  1  PC-write request, fed to the conditional stage.
- RegW  output  1  register-write request, fed to the conditional stage.
- MemW  output  1  memory-write request, fed to the conditional stage.
- FlagW  output  2  flag-write enables; [1] = N,Z and [0] = C,V.
- IRWrite  output  1  instruction register load enable.
- NextPC  output  1  unconditional PC update (PC+4).
- AdrSrc  output  1  memory address select; 0 = PC, 1 = ALU result.
- ResultSrc  output  2  result mux select; 00 = ALUOut, 01 = Data, 10 = ALU.
- ALUSrcA  output  1  ALU A select; 0 = register A, 1 = PC.
- ALUSrcB  output  2  ALU B select; 00 = register, 01 = extended immediate, 10 = constant 4.
- ALUControl  output  2  ALU operation; 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ImmSrc  output  2  immediate format; equals Op.
- RegSrc  output  2  register-address source selects.
- State  output  STATE_W  current state, for debug and verification.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH on the next clock.
- Reset: while reset=1 at a clock edge, State <= FETCH. This applies regardless of the current state, including mid-instruction. After reset the outputs equal the FETCH decode on the following cycle. No pending write survives reset.
- Transitions, one per clock:
  - FETCH -> DECODE.
  - DECODE, by Op:
    - Op=00, Funct[5]=0 -> EXECR.
    - Op=00, Funct[5]=1 -> EXECI.
    - Op=01 -> MEMADR.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (treated as a NOP).
  - MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR or EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Latency: data-processing = 4 cycles, LDR = 5, STR = 4, B = 3, Op=11 = 2.
- Moore outputs (any output not listed for a state is 0):
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW = NOT cmp.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decoder (ALUOp is internal):
  - ALUOp=0 -> ALUControl=00, FlagW=00.
  - ALUOp=1, by Funct[4:1]:
    - 0100 -> ADD, 00.
    - 0010 -> SUB, 01.
    - 0000 -> AND, 10.
    - 1100 -> ORR, 11.
    - 1010 -> CMP: 01, and cmp=1.
    - Any other code -> 00, FlagW=00.
  - With ALUOp=1: FlagW[1] = Funct[0]; FlagW[0] = Funct[0] AND (ADD or SUB or CMP).
  - FlagW is nonzero only in EXECR/EXECI, so flags are written exactly once per instruction.
- PCS = Branch OR (Rd==15 AND RegW). PCS asserts only in ALUWB, MEMWB or BRANCH.
- ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01). Both are combinational from the inputs in every state.
- All outputs are glitch-free functions of State plus Funct/Rd/Op. There are no combinational paths from reset to the outputs.

Test Plan:
- Reset held 2 cycles from an arbitrary state -> State=0, IRWrite=1, NextPC=1, RegW=MemW=PCS=0.
- ADDS register (Op=00, Funct=001001, Rd=3) -> States 0,1,6,8,0. EXECR: ALUControl=00, FlagW=11. ALUWB: RegW=1, PCS=0.
- LDR (Op=01, Funct=011001, Rd=15) -> States 0,1,2,3,4,0. MEMREAD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1, PCS=1.
- STR (Op=01, Funct=011000) -> States 0,1,2,5,0. MEMW=1 only in state 5. Branch (Op=10) -> States 0,1,9,0 with PCS=1 in state 9.
- CMP immediate (Op=00, Funct=110101) -> States 0,1,7,8. EXECI: ALUControl=01, FlagW=11. ALUWB: RegW=0.
- Reset asserted in MEMWRITE -> next state 0 and MemW=0 on that edge. Op=11 in DECODE -> returns to 0 with no write strobes.
